// File: rtl/exec_result_demux.sv
// Registered 1-to-2 result demux with a small FIFO per consumer channel.
// Optional per-channel accept counters are enabled by EXEC_RESULT_DEMUX_STATS_EN.
module exec_result_demux #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  input  logic             selectDest,
  output logic             outValidZero,
  input  logic             outReadyZero,
  output logic [WIDTH-1:0] outDataZero,
  output logic             outValidOne,
  input  logic             outReadyOne,
  output logic [WIDTH-1:0] outDataOne
`ifdef EXEC_RESULT_DEMUX_STATS_EN
  ,
  output logic [15:0]      countZero,
  output logic [15:0]      countOne
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_q   [2];
  logic [PW-1:0]    wr_d   [2];
  logic [PW-1:0]    rd_q   [2];
  logic [PW-1:0]    rd_d   [2];
  logic [CW-1:0]    cnt_q  [2];
  logic [CW-1:0]    cnt_d  [2];
  logic [WIDTH-1:0] mem_q  [2][DEPTH];
  logic [WIDTH-1:0] mem_d  [2][DEPTH];
  logic [WIDTH-1:0] head_q [2];
  logic [WIDTH-1:0] head_d [2];
  logic             full   [2];
  logic             push   [2];
  logic             pop    [2];
  logic [1:0]       out_ready;

  always_comb begin
    out_ready = {outReadyOne, outReadyZero};
    for (int c = 0; c < 2; c++) begin
      full[c] = (cnt_q[c] == CW'(DEPTH));
    end
    // Full blocks the push even if the head pops this same cycle.
    inReady = selectDest ? !full[1] : !full[0];

    for (int c = 0; c < 2; c++) begin
      push[c]   = inValid && inReady && (selectDest == (c == 1));
      pop[c]    = (cnt_q[c] != '0) && out_ready[c];
      wr_d[c]   = wr_q[c];
      rd_d[c]   = rd_q[c];
      cnt_d[c]  = cnt_q[c];
      mem_d[c]  = mem_q[c];
      head_d[c] = head_q[c];

      if (push[c]) begin
        mem_d[c][wr_q[c]] = inData;
        wr_d[c]           = wr_q[c] + PW'(1);
      end
      if (pop[c]) begin
        rd_d[c] = rd_q[c] + PW'(1);
      end
      if (push[c] && !pop[c]) begin
        cnt_d[c] = cnt_q[c] + CW'(1);
      end else if (pop[c] && !push[c]) begin
        cnt_d[c] = cnt_q[c] - CW'(1);
      end

      // Head register tracks the next entry; an emptied channel keeps its last head.
      if (cnt_d[c] != '0) begin
        head_d[c] = mem_d[c][rd_d[c]];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int c = 0; c < 2; c++) begin
        wr_q[c]   <= '0;
        rd_q[c]   <= '0;
        cnt_q[c]  <= '0;
        head_q[c] <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[c][e] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        wr_q[c]   <= wr_d[c];
        rd_q[c]   <= rd_d[c];
        cnt_q[c]  <= cnt_d[c];
        head_q[c] <= head_d[c];
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[c][e] <= mem_d[c][e];
        end
      end
    end
  end

  assign outValidZero = (cnt_q[0] != '0);
  assign outValidOne  = (cnt_q[1] != '0);
  assign outDataZero  = head_q[0];
  assign outDataOne   = head_q[1];

`ifdef EXEC_RESULT_DEMUX_STATS_EN
  logic [15:0] count_zero_q, count_zero_d;
  logic [15:0] count_one_q,  count_one_d;

  always_comb begin
    count_zero_d = count_zero_q + 16'(push[0]);
    count_one_d  = count_one_q  + 16'(push[1]);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_zero_q <= '0;
      count_one_q  <= '0;
    end else begin
      count_zero_q <= count_zero_d;
      count_one_q  <= count_one_d;
    end
  end

  assign countZero = count_zero_q;
  assign countOne  = count_one_q;
`endif

endmodule

// File: tb/tb_exec_result_demux.sv
// Directed bench for exec_result_demux with a per-channel scoreboard queue.
module tb_exec_result_demux;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             resetN;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] inData;
  logic             selectDest;
  logic             outValidZero;
  logic             outReadyZero;
  logic [WIDTH-1:0] outDataZero;
  logic             outValidOne;
  logic             outReadyOne;
  logic [WIDTH-1:0] outDataOne;
`ifdef EXEC_RESULT_DEMUX_STATS_EN
  logic [15:0]      countZero;
  logic [15:0]      countOne;
`endif

  exec_result_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .inValid      (inValid),
    .inReady      (inReady),
    .inData       (inData),
    .selectDest   (selectDest),
    .outValidZero (outValidZero),
    .outReadyZero (outReadyZero),
    .outDataZero  (outDataZero),
    .outValidOne  (outValidOne),
    .outReadyOne  (outReadyOne),
    .outDataOne   (outDataOne)
`ifdef EXEC_RESULT_DEMUX_STATS_EN
    ,
    .countZero    (countZero),
    .countOne     (countOne)
`endif
  );

  always #5 clk = ~clk;

  int passes = 0;
  int checks = 0;
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] last0, last1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_reset_state();
    chk("rst_inReady", inReady, 1);
    chk("rst_outValidZero", outValidZero, 0);
    chk("rst_outValidOne", outValidOne, 0);
    chk("rst_outDataZero", outDataZero, 0);
    chk("rst_outDataOne", outDataOne, 0);
`ifdef EXEC_RESULT_DEMUX_STATS_EN
    chk("rst_countZero", countZero, 0);
    chk("rst_countOne", countOne, 0);
`endif
  endtask

  // One clock: drive before the edge, check against the model, then update the model.
  task automatic cycle(input logic v, input logic s, input logic [31:0] d,
                       input logic r0, input logic r1, input bit full_chk = 1'b1);
    logic exp_rdy;
    @(negedge clk);
    inValid = v; selectDest = s; inData = d; outReadyZero = r0; outReadyOne = r1;
    #1;
    exp_rdy = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    chk("inReady", inReady, exp_rdy);
    if (full_chk) begin
      chk("outValidZero", outValidZero, q0.size() != 0);
      chk("outValidOne", outValidOne, q1.size() != 0);
      chk("outDataZero", outDataZero, (q0.size() != 0) ? q0[0] : last0);
      chk("outDataOne", outDataOne, (q1.size() != 0) ? q1[0] : last1);
    end
    @(posedge clk);
    if (r0 && q0.size() != 0) last0 = q0.pop_front();
    if (r1 && q1.size() != 0) last1 = q1.pop_front();
    if (v && exp_rdy) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    last0 = '0; last1 = '0;
  endtask

  initial begin
    resetN = 1'b0; inValid = 1'b0; inData = '0; selectDest = 1'b0;
    outReadyZero = 1'b0; outReadyOne = 1'b0;
    model_reset();
    #12;
    chk_reset_state();
    @(negedge clk);
    resetN = 1'b1;

    // Single push to channel 0, consumer stalled.
    cycle(1, 0, 32'h1111_1111, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("ch0_first_valid", outValidZero, 1);
    chk("ch0_first_data", outDataZero, 32'h1111_1111);
    chk("ch1_stays_idle", outValidOne, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);

    // Fill channel 0, full blocks even while the head pops.
    cycle(1, 0, 32'hA, 0, 0);
    cycle(1, 0, 32'hB, 0, 0);
    cycle(1, 0, 32'hC, 0, 0);
    chk("full_blocks_C", inReady, 0);
    cycle(1, 0, 32'hC, 1, 0);
    chk("full_pop_same_cycle", inReady, 0);
    cycle(1, 0, 32'hC, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);

    // Channel 0 full and stalled; destination switches while blocked.
    cycle(1, 0, 32'h1, 0, 0);
    cycle(1, 0, 32'h2, 0, 0);
    cycle(1, 0, 32'h55, 0, 0);
    cycle(1, 1, 32'h55, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("ch1_data_55", outDataOne, 32'h55);
    chk("ch0_still_full", outValidZero, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0);

    // Alternating destinations, both consumers ready.
    for (int i = 1; i <= 8; i++) cycle(1, ((i % 2) == 0), 32'(i), 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    chk("alt_last0", last0, 32'h7);
    chk("alt_last1", last1, 32'h8);

    // Wrap pointers with a mix of stalls.
    for (int i = 0; i < 24; i++)
      cycle(1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Asynchronous reset between clock edges with both channels loaded.
    cycle(1, 0, 32'hDEAD_0000, 0, 0);
    cycle(1, 1, 32'hDEAD_0001, 0, 0);
    @(posedge clk);
    #2;
    inValid = 1'b0;
    resetN = 1'b0;
    #1;
    chk("async_valid0_drop", outValidZero, 0);
    chk("async_valid1_drop", outValidOne, 0);
    model_reset();
    chk_reset_state();
    @(negedge clk);
    resetN = 1'b1;
    #1;
    chk("post_reset_inReady", inReady, 1);
    cycle(0, 0, 0, 0, 0);

`ifdef EXEC_RESULT_DEMUX_STATS_EN
    for (int i = 0; i < 65537; i++) cycle(1, 1, 32'(i), 1, 1, 1'b0);
    cycle(0, 0, 0, 1, 1);
    chk("stats_countOne_wrap", countOne, 16'd1);
    chk("stats_countZero", countZero, 16'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/exec_result_demux.md
Name: exec_result_demux

Overview:
- Registered 1-to-2 demultiplexer at the output of the execute stage. It is the return-side counterpart of the ALU operand select mux.
- Steers each ALU result to one of two consumers, selected per transfer: channel 0 is register writeback, channel 1 is the load/store address path.
- Each channel has its own small FIFO with valid/ready handshakes, so either consumer can stall without losing results.

Parameters:
- WIDTH, 32, data width of a result.
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock
- resetN  input  1  asynchronous active-low reset
- inValid  input  1  producer offers a result this cycle
- inReady  output  1  demux accepts the offered result
- inData  input  WIDTH  ALU result
- selectDest  input  1  destination channel; 0 = writeback, 1 = address path
- outValidZero  output  1  channel 0 head valid
- outReadyZero  input  1  channel 0 consumer accepts
- outDataZero  output  WIDTH  channel 0 head data
- outValidOne  output  1  channel 1 head valid
- outReadyOne  input  1  channel 1 consumer accepts
- outDataOne  output  WIDTH  channel 1 head data
- Stats ports (present only with the optional feature): countZero  output  16; countOne  output  16

Behaviour:
- Reset is asynchronous and active-low, on resetN, in the single clock domain clk. Assertion acts immediately, independent of clk.
- Reset values:
  - all FIFO pointers and occupancy counts = 0
  - outValidZero = outValidOne = 0
  - outDataZero = outDataOne = 0
  - inReady = 1 (both FIFOs empty)
  - stats counters = 0
- Input transfer: occurs when inValid && inReady at a rising clk edge. inData is written into the FIFO chosen by selectDest.
- inReady = NOT full(selected channel). It is a function of selectDest and registered occupancy only; it has no combinational path from outReadyZero or outReadyOne.
- Output transfer on channel k: occurs when outValidK && outReadyK. The FIFO head pops on that edge.
- outValidK = (occupancy K != 0). outDataK = head entry, driven from storage.
- Latency: a result accepted at edge N is visible on its channel output after edge N; the earliest pop is at edge N+1. There is no same-cycle bypass.
- Ordering:
  - Strict FIFO order within each channel.
  - No ordering relation between channels; channel 1 may drain before older channel 0 entries.
- Occupancy per channel runs 0..DEPTH, width clog2(DEPTH)+1. It changes by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
- Boundary conditions:
  - Full channel, pop in the same cycle: inReady stays 0 that cycle (full blocks regardless of pop). The push completes the cycle after the pop.
  - Empty channel, push in the same cycle: outValid stays 0 this cycle and rises after the edge.
  - Write and read pointers wrap modulo DEPTH.
  - Full on one channel never blocks transfers to the other channel.
  - selectDest may change while inValid is high and inReady is low. The producer holds inData, but the destination is sampled only on the accepting edge.
  - Pops with outValidK = 0 are ignored. Pushes with inReady = 0 are ignored, with no state change.
  - Reset mid-operation: all stored entries are discarded and the outputs return to reset values immediately.
- outData of an empty channel keeps the last head value; consumers must qualify it with outValid.

Optional Feature:
- Macro: EXEC_RESULT_DEMUX_STATS_EN.
- Defined:
  - countZero and countOne are present.
  - Each is a 16-bit counter incremented on every accepted input transfer to that channel.
  - Counters wrap 0xFFFF -> 0x0000 and reset to 0.
- Undefined: the ports and counter logic are absent. Datapath behaviour is identical in both builds.

Test Plan:
- Reset, then push 0x11111111 to channel 0 with outReadyZero = 0 -> outValidZero = 1 after the edge, outDataZero = 0x11111111; channel 1 stays invalid.
- Push 0xA, 0xB, 0xC to channel 0 with outReadyZero held 0 (DEPTH = 2) -> inReady = 0 while 0xC is offered. Raise outReadyZero -> pops 0xA, then 0xB; 0xC is accepted the cycle after the first pop.
- Channel 0 full and stalled, push 0x55 to channel 1 -> accepted immediately; outDataOne = 0x55 next cycle while channel 0 remains full.
- Alternate selectDest 0/1 with both readies at 1, 8 transfers with data 1..8 -> channel 0 sees 1,3,5,7; channel 1 sees 2,4,6,8; no bubbles after first-cycle latency.
- Assert resetN = 0 asynchronously between edges with both channels holding data -> outValidZero/One drop immediately without a clock edge; inReady = 1 once reset releases; stats = 0.
- With EXEC_RESULT_DEMUX_STATS_EN, 65537 accepted transfers to channel 1 -> countOne = 1, countZero = 0.
